// File: rtl/muldiv_if.sv
// muldiv_if: pipeline-side bundle for the HI/LO multiply/divide unit.
//
// Handshake: an instruction is presented by holding en=1 with its Funct and
// operands. It is accepted on a rising edge where busy=0 and stall=0. While
// stall=1 the pipeline must keep en/Funct/operands steady and present them
// again; there is no separate ready signal because ~stall plays that role.
//
// Signals (master = pipeline, slave = muldiv_unit):
//   en        valid HI/LO-family R-type instruction in EX
//   Funct     6-bit R-type function code
//   sign      1 = signed operands (sampled only when an op starts)
//   A, B      rs / rt operands
//   rd_data   HI for mfhi, LO for mflo, otherwise 0 (combinational)
//   busy      registered, high while an op is running
//   done      registered, one-cycle pulse when mult/div writes HI/LO
//   stall     en & busy
//   dbg_state current FSM state (IDLE=0, RUN=1, FIX=2)
//   flush     squash of an outstanding op (only with MULDIV_ABORT_EN)
interface muldiv_if #(parameter int WIDTH = 32);
  logic             en;
  logic [5:0]       Funct;
  logic             sign;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             stall;
  logic [1:0]       dbg_state;
`ifdef MULDIV_ABORT_EN
  logic             flush;
`endif

  modport master (
    output en, Funct, sign, A, B,
`ifdef MULDIV_ABORT_EN
    output flush,
`endif
    input  rd_data, busy, done, stall, dbg_state
  );

  modport slave (
    input  en, Funct, sign, A, B,
`ifdef MULDIV_ABORT_EN
    input  flush,
`endif
    output rd_data, busy, done, stall, dbg_state
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit sitting beside the ALU in EX.
// Executes mult/multu/div/divu into HI/LO (WIDTH iterations plus one sign-fix
// cycle) and serves mthi/mtlo/mfhi/mflo.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    muldiv_if.slave (en, Funct, sign, A, B, rd_data, busy, done,
//          stall, dbg_state, and flush when MULDIV_ABORT_EN is defined)
//
// Optional feature: define MULDIV_ABORT_EN to add the flush input, which
// squashes an op in RUN or FIX (HI/LO untouched, no done pulse) and blocks
// acceptance of any coincident en op in IDLE.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t             state;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   a_raw;    // original dividend, returned as HI on /0
  logic [WIDTH-1:0]   opnd;     // |multiplicand| or |divisor|
  logic [2*WIDTH-1:0] acc;      // mult: {partial, multiplier}; div: {rem, quot}
  logic [CNT_W-1:0]   count;
  logic               is_div, neg_res, neg_rem, div_zero;
  logic               busy_r, done_r;
  logic               flush_now;

`ifdef MULDIV_ABORT_EN
  assign flush_now = bus.flush;
`else
  assign flush_now = 1'b0;
`endif

  // 0x18..0x1B all share the upper four Funct bits.
  logic is_muldiv;
  assign is_muldiv = (bus.Funct[5:2] == 4'b0110);

  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = (bus.sign && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign abs_b = (bus.sign && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit (acc[0]) is set, then shift right keeping carry.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

  // Restoring step: shift remainder left pulling in the next dividend bit,
  // trial-subtract; a borrow (trial MSB set) means keep the shifted value.
  logic [WIDTH:0] div_shift, div_trial;
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_trial = div_shift - {1'b0, opnd};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot, rem;
  assign prod_fix = neg_res ? -acc : acc;
  assign quot     = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      a_raw    <= '0;
      opnd     <= '0;
      acc      <= '0;
      count    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en && !flush_now) begin
            if (is_muldiv) begin
              is_div   <= bus.Funct[1];
              a_raw    <= bus.A;
              opnd     <= bus.Funct[1] ? abs_b : abs_a;
              acc      <= bus.Funct[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
              neg_res  <= bus.sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
              neg_rem  <= bus.sign & bus.A[WIDTH-1];
              div_zero <= (bus.B == '0);
              count    <= '0;
              busy_r   <= 1'b1;
              state    <= RUN;
            end else if (bus.Funct == F_MTHI) begin
              hi <= bus.A;
            end else if (bus.Funct == F_MTLO) begin
              lo <= bus.A;
            end
          end
        end
        RUN: begin
          if (flush_now) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            if (is_div)
              acc <= {(div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                      acc[WIDTH-2:0], ~div_trial[WIDTH]};
            else
              acc <= {mul_sum, acc[WIDTH-1:1]};
            if (count == LAST) state <= FIX;
            else               count <= count + 1'b1;
          end
        end
        FIX: begin
          busy_r <= 1'b0;
          state  <= IDLE;
          if (!flush_now) begin
            done_r <= 1'b1;
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (div_zero) begin
              // Divide by zero ignores signedness: LO all ones, HI = raw A.
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= neg_rem ? -rem : rem;
              lo <= neg_res ? -quot : quot;
            end
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.rd_data = '0;
    case (bus.Funct)
      F_MFHI:  bus.rd_data = hi;
      F_MFLO:  bus.rd_data = lo;
      default: bus.rd_data = '0;
    endcase
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.stall     = bus.en & busy_r;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [5:0]  f;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.en = 1'b0; bus.Funct = 6'h0; bus.sign = 1'b0; bus.A = '0; bus.B = '0;
`ifdef MULDIV_ABORT_EN
    bus.flush = 1'b0;
`endif
  endtask

  // Presents an op for one edge (edge 0); returns at the negedge after it,
  // with operands scrambled to show they are ignored once started.
  task automatic start_op(input logic [5:0] f, input logic sg, input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clk);
    bus.en = 1'b1; bus.Funct = f; bus.sign = sg; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.en = 1'b0; bus.Funct = 6'h0;
    bus.sign = 1'($urandom_range(0, 1));
    bus.A = $urandom; bus.B = $urandom;
  endtask

  // Counts busy cycles (bounded), then checks the done pulse and its clear.
  task automatic wait_done(input string tag);
    int cycles = 0;
    while (bus.busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(cycles), 32'd33);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd1);
    @(negedge clk);
    check({tag, "_done_clear"}, 32'(bus.done), 32'd0);
  endtask

  // Reads HI then LO via mfhi/mflo in the low clock phase; expectations pop
  // from the scoreboard queue (HI first, then LO).
  task automatic read_hilo(input string tag);
    logic [31:0] e;
    bus.en = 1'b1; bus.Funct = F_MFHI;
    #1;
    e = exp_q.pop_front();
    check({tag, "_hi"}, bus.rd_data, e);
    check({tag, "_stall"}, 32'(bus.stall), 32'd0);
    bus.Funct = F_MFLO;
    #1;
    e = exp_q.pop_front();
    check({tag, "_lo"}, bus.rd_data, e);
    bus.en = 1'b0; bus.Funct = 6'h0;
  endtask

  task automatic expect_hilo(input logic [31:0] h, input logic [31:0] l);
    exp_q.push_back(h);
    exp_q.push_back(l);
  endtask

  task automatic add_vec(input string n, input logic [5:0] f, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l);
    vec_t v;
    v.name = n; v.f = f; v.sg = sg; v.a = a; v.b = b; v.hi = h; v.lo = l;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_stall;
    int guard;

    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    expect_hilo(32'h0, 32'h0);
    read_hilo("rst");
    reset = 1'b0;

    // Hand-computed directed vectors.
    add_vec("multu_max", F_MULTU, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    add_vec("mult_neg",  F_MULT,  1'b1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    add_vec("multu_uns", F_MULTU, 1'b0, 32'hFFFFFFFD, 32'd7,        32'h00000006, 32'hFFFFFFEB);
    add_vec("div_m7_2",  F_DIV,   1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    add_vec("div_7_m2",  F_DIV,   1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    add_vec("divu_9_2",  F_DIVU,  1'b0, 32'd9,        32'd2,        32'h00000001, 32'h00000004);
    add_vec("divu_by0",  F_DIVU,  1'b0, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF);
    add_vec("div_by0",   F_DIV,   1'b1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    add_vec("div_ovf",   F_DIV,   1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    foreach (vecs[i]) begin
      start_op(vecs[i].f, vecs[i].sg, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_run"}, 32'(bus.dbg_state), 32'd1);
      wait_done(vecs[i].name);
      expect_hilo(vecs[i].hi, vecs[i].lo);
      read_hilo(vecs[i].name);
    end

    // mthi / mtlo: single-edge writes, never busy or stalling.
    @(negedge clk);
    bus.en = 1'b1; bus.Funct = F_MTHI; bus.A = 32'h1234;
    #1;
    check("mthi_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    check("mthi_busy", 32'(bus.busy), 32'd0);
    expect_hilo(32'h1234, 32'h80000000);
    read_hilo("mthi");
    @(negedge clk);
    bus.en = 1'b1; bus.Funct = F_MTLO; bus.A = 32'hABCD;
    @(negedge clk);
    expect_hilo(32'h1234, 32'hABCD);
    read_hilo("mtlo");

    // multu 6*7 with an mflo held behind it: stalls every busy cycle.
    @(negedge clk);
    bus.en = 1'b1; bus.Funct = F_MULTU; bus.sign = 1'b0; bus.A = 32'd6; bus.B = 32'd7;
    @(negedge clk);
    bus.Funct = F_MFLO; bus.A = $urandom; bus.B = $urandom;
    n_stall = 0;
    guard = 0;
    while (bus.busy && guard < 100) begin
      guard++;
      if (bus.stall) n_stall++;
      @(negedge clk);
    end
    check("held_stall_cycles", 32'(n_stall), 32'd33);
    check("held_stall_release", 32'(bus.stall), 32'd0);
    check("held_done", 32'(bus.done), 32'd1);
    check("held_mflo", bus.rd_data, 32'd42);
    bus.en = 1'b0; bus.Funct = 6'h0;

    // Reset at edge 10 of a running op clears everything.
    start_op(F_MULTU, 1'b0, 32'hFFFFFFFF, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_state", 32'(bus.dbg_state), 32'd0);
    expect_hilo(32'h0, 32'h0);
    read_hilo("midrst");
    reset = 1'b0;

`ifdef MULDIV_ABORT_EN
    @(negedge clk);
    bus.en = 1'b1; bus.Funct = F_MTHI; bus.A = 32'h77;
    @(negedge clk);
    bus.Funct = F_MTLO; bus.A = 32'h88;
    @(negedge clk);
    bus.en = 1'b0;
    start_op(F_DIVU, 1'b0, 32'd9, 32'd2);
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_state", 32'(bus.dbg_state), 32'd0);
    guard = 0;
    repeat (40) begin
      if (bus.done) guard++;
      @(negedge clk);
    end
    check("flush_no_done", 32'(guard), 32'd0);
    expect_hilo(32'h77, 32'h88);
    read_hilo("flush");
    @(negedge clk);
    bus.en = 1'b1; bus.Funct = F_MTHI; bus.A = 32'h99; bus.flush = 1'b1;
    @(negedge clk);
    bus.en = 1'b0; bus.flush = 1'b0;
    expect_hilo(32'h77, 32'h88);
    read_hilo("flush_idle");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside the ALU.
- Executes mult/multu/div/divu into HI/LO and serves mthi/mtlo/mfhi/mflo.
- Takes the R-type Funct and the `sign` signal produced by ALU control decode. Asserts `stall` to freeze IF/ID/EX while a HI/LO op is outstanding.

Parameters:
- WIDTH, 32, operand/HI/LO width; RUN lasts WIDTH cycles.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- en  in  1  valid R-type instruction in EX with a HI/LO-family Funct
- Funct  in  6  0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo
- sign  in  1  1 = signed operands; sampled only at start
- A  in  WIDTH  rs operand (multiplicand/dividend; mthi/mtlo data)
- B  in  WIDTH  rt operand (multiplier/divisor)
- rd_data  out  WIDTH  combinational: HI for 0x10, LO for 0x12, else 0
- busy  out  1  registered, high while state != IDLE
- done  out  1  registered, one-cycle pulse when HI/LO updated by mult/div
- stall  out  1  combinational: en & busy

Behaviour:
- States: IDLE, RUN, FIX.
- Reset: state=IDLE, HI=LO=0, count=0, busy=0, done=0, internal regs=0.
  - Reset has priority in every state.
  - A reset mid-operation discards the op and does not restore HI/LO.
- IDLE, en & Funct in {0x18..0x1B} at edge 0:
  - Latch |A|, |B| (magnitudes when sign=1, raw when sign=0), the result-sign flags and the op kind.
  - count=0, go to RUN.
- IDLE, en & Funct=0x11: HI<=A at that edge, no busy. Funct=0x13: LO<=A likewise.
- IDLE, en & Funct 0x10/0x12: no state change. rd_data is valid in the same cycle.
- en with any other Funct: ignored.
- RUN: one iteration per edge, edges 1..WIDTH.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring; shift remainder, trial-subtract, set quotient bit.
  - After iteration WIDTH-1 (count==WIDTH-1), go to FIX.
- FIX, edge WIDTH+1 (33 for default):
  - Apply sign correction. Product is negated if sign(A)^sign(B). Quotient is negated if sign(A)^sign(B). Remainder takes the sign of A.
  - Write HI/LO: mult gives HI=upper, LO=lower; div gives LO=quotient, HI=remainder.
  - done<=1 for exactly one cycle, then go to IDLE.
- busy is high after edge 0 through edge WIDTH+1 inclusive.
- While busy, en is not accepted:
  - stall=1; the pipeline holds the instruction and re-presents it.
  - The op is accepted on the first edge where busy=0.
  - mfhi/mflo after the FIX edge read the new values.
- Divide by zero (B=0), either signedness: LO=all ones, HI=A (original, unsigned-extended value); cycle count unchanged.
- Signed overflow (A=0x80000000, B=0xFFFFFFFF, div): LO=0x80000000, HI=0.
- Operands and sign are ignored after edge 0; changes during RUN have no effect.
- Counter never wraps: RUN always exits at count==WIDTH-1.

Optional Feature:
- MULDIV_ABORT_EN defined:
  - Extra input port `flush` (1 bit), used for branch/exception squash.
  - flush=1 in RUN or FIX returns to IDLE at that edge; HI/LO unchanged, done stays 0.
  - flush in IDLE blocks acceptance of a coincident en op.
- MULDIV_ABORT_EN not defined: no `flush` port; every accepted op runs to completion.

Test Plan:
- multu A=0xFFFFFFFF, B=0xFFFFFFFF, sign=0 -> busy for 33 cycles, done pulse at edge 33, HI=0xFFFFFFFE, LO=0x00000001.
- mult A=0xFFFFFFFD (-3), B=7, sign=1 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; div A=-7, B=2, sign=1 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=100, B=0 -> LO=0xFFFFFFFF, HI=100; div A=0x80000000, B=0xFFFFFFFF, sign=1 -> LO=0x80000000, HI=0.
- mthi A=0x1234 then mflo/mfhi next cycle -> rd_data=0x1234 for 0x10; stall=0 throughout.
- Start multu 6*7; held mflo en during busy -> stall=1 every busy cycle, then rd_data=42 after edge 33; reset at edge 10 of another op -> busy=0, HI=LO=0 next cycle.
- MULDIV_ABORT_EN: divu 9/2 with flush at edge 5 -> IDLE at edge 5, no done pulse, HI/LO keep prior values.
